// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester byte streams, the UART TX FIFO write port and the
//   arbiter status outputs into one interface.
//
//   Parameters (must match the arbiter instance):
//     data_bits  byte width
//     num_req    number of requesters
//
//   Signals:
//     req_valid  [num_req]            requester i has a byte on its slice
//     req_data   [num_req*data_bits]  requester i byte at [i*data_bits +: data_bits]
//     req_last   [num_req]            requester i's current byte ends its frame
//     req_ready  [num_req]            byte accepted when valid & ready
//     tx_full                         UART TX FIFO full
//     fifo_wr_en                      UART TX FIFO write strobe
//     fifo_din   [data_bits]          UART TX FIFO write data
//     grant      [num_req]            one-hot registered grant, zero when idle
//     busy                            a grant is active
//
//   Modports:
//     slave   the arbiter itself
//     master  the surroundings (requesters plus the UART top)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int data_bits = 8,
    parameter int num_req   = 4
);
    logic [num_req-1:0]           req_valid;
    logic [num_req*data_bits-1:0] req_data;
    logic [num_req-1:0]           req_last;
    logic [num_req-1:0]           req_ready;
    logic                         tx_full;
    logic                         fifo_wr_en;
    logic [data_bits-1:0]         fifo_din;
    logic [num_req-1:0]           grant;
    logic                         busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, fifo_wr_en, fifo_din, grant, busy
    );

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, fifo_wr_en, fifo_din, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing the UART TX FIFO write port among num_req
//   byte-stream requesters. A grant is held for a whole frame (until req_last)
//   or for max_burst bytes, whichever comes first, so frames never interleave.
//   Each release costs one IDLE cycle before the next grant.
//
//   Parameters:
//     data_bits  byte width (matches the UART top)
//     num_req    number of requesters, 2..8
//     max_burst  maximum bytes per grant, 1..256
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    uart_tx_arbiter_if.slave (requesters, FIFO write port, status)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int data_bits = 8,
    parameter int num_req   = 4,
    parameter int max_burst = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);
    localparam int ptr_w = $clog2(num_req);
    localparam int cnt_w = $clog2(max_burst) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [num_req-1:0] grant_q, grant_d;
    logic [ptr_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [cnt_w-1:0]   beat_q, beat_d;
    logic [ptr_w-1:0]   g_idx;
    logic [ptr_w-1:0]   pick_idx;
    logic               transfer;

    // Index of the currently granted requester (grant_q is one-hot in BURST).
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < num_req; i++) begin
            if (grant_q[i]) g_idx = ptr_w'(i);
        end
    end

    // First valid requester at or after rr_ptr, wrapping. The loop walks the
    // offsets from far to near so the nearest valid requester is written last.
    always_comb begin
        pick_idx = '0;
        for (int k = num_req - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr_q) + k) % num_req])
                pick_idx = ptr_w'((int'(rr_ptr_q) + k) % num_req);
        end
    end

    // Write-port steering. Only the granted requester sees ready; ready tracks
    // tx_full with no register so throughput is one byte per cycle. The data
    // mux depends only on registered state, keeping req_data off control paths.
    always_comb begin
        bus.req_ready = '0;
        transfer      = 1'b0;
        bus.fifo_din  = '0;
        if (state_q == BURST) begin
            bus.fifo_din = bus.req_data[g_idx*data_bits +: data_bits];
            if (!reset) begin
                bus.req_ready[g_idx] = ~bus.tx_full;
                transfer             = bus.req_valid[g_idx] & ~bus.tx_full;
            end
        end
    end

    assign bus.fifo_wr_en = transfer;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q == BURST);

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = num_req'(1) << pick_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                // A full FIFO blocks the transfer, so a last byte waiting on
                // tx_full does not release the grant either.
                if (transfer) begin
                    beat_d = beat_q + cnt_w'(1);
                    if (bus.req_last[g_idx] || beat_q == cnt_w'(max_burst - 1)) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (g_idx == ptr_w'(num_req - 1)) ? '0
                                                                  : g_idx + ptr_w'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the blocks are evaluated.
    // NOTE: the reset is asynchronous; reset aborts a frame immediately and
    // arbitration restarts from requester 0 once it is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (data_bits=8, num_req=4, max_burst=16).
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge. Expected values are written out by hand for each step.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int data_bits = 8;
    localparam int num_req   = 4;
    localparam int max_burst = 16;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter_if #(.data_bits(data_bits), .num_req(num_req)) bus ();

    uart_tx_arbiter #(
        .data_bits (data_bits),
        .num_req   (num_req),
        .max_burst (max_burst)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_byte(input int r, input logic [7:0] v);
        bus.req_data[r*data_bits +: data_bits] = v;
    endtask

    // Round-robin frame byte b of grant number k.
    function automatic logic [7:0] rr_byte(input int k, input int b);
        return 8'(k * 16 + b + 1);
    endfunction

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_wr_en", bus.fifo_wr_en, 1'b0);
        check("rst_din", bus.fifo_din, 8'h00);

        // ---------------- single 3-byte frame, requester 0 ----------------
        tick();
        reset         = 1'b0;
        bus.req_valid = 4'b0001;
        set_byte(0, 8'h11);
        settle();
        check("t1_idle_busy", bus.busy, 1'b0);
        check("t1_idle_wr", bus.fifo_wr_en, 1'b0);
        tick();
        settle();
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_busy", bus.busy, 1'b1);
        check("t1_ready", bus.req_ready, 4'b0001);
        check("t1_wr0", bus.fifo_wr_en, 1'b1);
        check("t1_din0", bus.fifo_din, 8'h11);
        tick();
        set_byte(0, 8'h22);
        settle();
        check("t1_wr1", bus.fifo_wr_en, 1'b1);
        check("t1_din1", bus.fifo_din, 8'h22);
        tick();
        set_byte(0, 8'h33);
        bus.req_last = 4'b0001;
        settle();
        check("t1_wr2", bus.fifo_wr_en, 1'b1);
        check("t1_din2", bus.fifo_din, 8'h33);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        check("t1_release_busy", bus.busy, 1'b0);
        check("t1_release_grant", bus.grant, 4'b0000);
        check("t1_release_wr", bus.fifo_wr_en, 1'b0);

        // ---------------- burst cap: req1 streams 20, req3 waiting ----------------
        // rr_ptr is 1 here, so requester 1 wins the first arbitration.
        tick();
        bus.req_valid = 4'b1010;
        set_byte(1, 8'h81);
        set_byte(3, 8'hC3);
        settle();
        check("t4_idle_busy", bus.busy, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            tick();
            set_byte(1, 8'(8'h80 + n));
            settle();
            check("t4_grant1", bus.grant, 4'b0010);
            check("t4_wr", bus.fifo_wr_en, 1'b1);
            check("t4_din", bus.fifo_din, 8'(8'h80 + n));
        end
        tick();
        set_byte(1, 8'h91);
        bus.req_last = 4'b1000;
        settle();
        check("t4_cap_release", bus.busy, 1'b0);
        tick();
        settle();
        check("t4_grant3", bus.grant, 4'b1000);
        check("t4_din3", bus.fifo_din, 8'hC3);
        check("t4_wr3", bus.fifo_wr_en, 1'b1);
        tick();
        bus.req_valid = 4'b0010;
        bus.req_last  = '0;
        settle();
        check("t4_bubble", bus.busy, 1'b0);
        for (int n = 17; n <= 20; n++) begin
            tick();
            set_byte(1, 8'(8'h80 + n));
            bus.req_last = (n == 20) ? 4'b0010 : 4'b0000;
            settle();
            check("t4_resume_grant", bus.grant, 4'b0010);
            check("t4_resume_wr", bus.fifo_wr_en, 1'b1);
            check("t4_resume_din", bus.fifo_din, 8'(8'h80 + n));
        end
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        check("t4_end_busy", bus.busy, 1'b0);

        // ---------------- backpressure on requester 2 ----------------
        tick();
        bus.req_valid = 4'b0100;
        set_byte(2, 8'hA0);
        settle();
        check("t3_idle_busy", bus.busy, 1'b0);
        tick();
        settle();
        check("t3_grant", bus.grant, 4'b0100);
        check("t3_din0", bus.fifo_din, 8'hA0);
        check("t3_wr0", bus.fifo_wr_en, 1'b1);
        tick();
        set_byte(2, 8'hA1);
        settle();
        check("t3_din1", bus.fifo_din, 8'hA1);
        tick();
        set_byte(2, 8'hA2);
        bus.tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t3_full_ready", bus.req_ready, 4'b0000);
            check("t3_full_wr", bus.fifo_wr_en, 1'b0);
            check("t3_full_grant", bus.grant, 4'b0100);
            tick();
        end
        bus.tx_full = 1'b0;
        settle();
        check("t3_resume_ready", bus.req_ready, 4'b0100);
        check("t3_resume_wr", bus.fifo_wr_en, 1'b1);
        check("t3_resume_din", bus.fifo_din, 8'hA2);
        tick();
        set_byte(2, 8'hA3);
        bus.req_last = 4'b0100;
        bus.tx_full  = 1'b1;
        settle();
        check("t3_last_full_wr", bus.fifo_wr_en, 1'b0);
        tick();
        bus.tx_full = 1'b0;
        settle();
        check("t3_last_held", bus.busy, 1'b1);
        check("t3_last_wr", bus.fifo_wr_en, 1'b1);
        check("t3_last_din", bus.fifo_din, 8'hA3);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        check("t3_end_busy", bus.busy, 1'b0);

        // ---------------- reset mid-frame on requester 3 ----------------
        tick();
        bus.req_valid = 4'b1000;
        set_byte(3, 8'hD0);
        settle();
        check("t6_idle_busy", bus.busy, 1'b0);
        tick();
        settle();
        check("t6_grant", bus.grant, 4'b1000);
        check("t6_din0", bus.fifo_din, 8'hD0);
        tick();
        set_byte(3, 8'hD1);
        settle();
        check("t6_din1", bus.fifo_din, 8'hD1);
        tick();
        set_byte(3, 8'hD2);
        reset = 1'b1;
        #1;
        check("t6_rst_grant", bus.grant, 4'b0000);
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_ready", bus.req_ready, 4'b0000);
        check("t6_rst_wr", bus.fifo_wr_en, 1'b0);
        tick();
        reset = 1'b0;

        // ---------------- round robin, all requesters valid ----------------
        // After reset rr_ptr is 0, so the order is 0, 1, 2, 3, 0.
        bus.req_valid = 4'b1111;
        for (int r = 0; r < num_req; r++) set_byte(r, rr_byte(r, 0));
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t2_bubble", bus.busy, 1'b0);
            tick();
            settle();
            check("t2_grant", bus.grant, 4'b0001 << (k % num_req));
            check("t2_wr0", bus.fifo_wr_en, 1'b1);
            check("t2_din0", bus.fifo_din, rr_byte(k, 0));
            tick();
            set_byte(k % num_req, rr_byte(k, 1));
            bus.req_last = 4'b0001 << (k % num_req);
            settle();
            check("t2_wr1", bus.fifo_wr_en, 1'b1);
            check("t2_din1", bus.fifo_din, rr_byte(k, 1));
            tick();
            bus.req_last = '0;
            set_byte(k % num_req, rr_byte(k + num_req, 0));
        end
        bus.req_valid = '0;
        settle();
        check("t2_end_busy", bus.busy, 1'b0);

        // ---------------- mid-frame gap on requester 0 ----------------
        // rr_ptr is 1; with only requester 0 valid the search wraps to 0.
        tick();
        bus.req_valid = 4'b0001;
        set_byte(0, 8'h50);
        settle();
        check("t5_idle_busy", bus.busy, 1'b0);
        tick();
        settle();
        check("t5_grant", bus.grant, 4'b0001);
        check("t5_din0", bus.fifo_din, 8'h50);
        tick();
        bus.req_valid = 4'b0010;
        set_byte(1, 8'h60);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t5_gap_grant", bus.grant, 4'b0001);
            check("t5_gap_wr", bus.fifo_wr_en, 1'b0);
            tick();
        end
        bus.req_valid = 4'b0011;
        set_byte(0, 8'h51);
        bus.req_last = 4'b0001;
        settle();
        check("t5_after_wr", bus.fifo_wr_en, 1'b1);
        check("t5_after_din", bus.fifo_din, 8'h51);
        tick();
        bus.req_valid = 4'b0010;
        bus.req_last  = '0;
        settle();
        check("t5_bubble", bus.busy, 1'b0);
        tick();
        bus.req_last = 4'b0010;
        settle();
        check("t5_grant1", bus.grant, 4'b0010);
        check("t5_din1", bus.fifo_din, 8'h60);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        check("t5_end_busy", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
